// File: rtl/laser_pkg.sv
// Shared types, constants and the squared-distance helper for the LASER host.
package laser_pkg;

    localparam int unsigned NPTS     = 40;
    localparam int unsigned COVER_R2 = 16;
    localparam int unsigned DRST_CYC = 2;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRST,
        ST_FEED,
        ST_RUN,
        ST_SCORE,
        ST_REPORT
    } state_t;

    function automatic logic [8:0] dist2(input logic [3:0] x0, input logic [3:0] y0,
                                         input logic [3:0] x1, input logic [3:0] y1);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic [4:0]        ax;
        logic [4:0]        ay;
        logic [7:0]        sx;
        logic [7:0]        sy;
        dx = $signed({1'b0, x0}) - $signed({1'b0, x1});
        dy = $signed({1'b0, y0}) - $signed({1'b0, y1});
        ax = dx[4] ? $unsigned(-dx) : $unsigned(dx);
        ay = dy[4] ? $unsigned(-dy) : $unsigned(dy);
        sx = {3'b000, ax} * {3'b000, ax};
        sy = {3'b000, ay} * {3'b000, ay};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/laser_host_if.sv
// Host <-> LASER engine connection: reset, point stream, results and DONE.
interface laser_host_if;

    logic       DUT_RST;
    logic [3:0] X;
    logic [3:0] Y;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       DONE;

    modport master (output DUT_RST, X, Y, input C1X, C1Y, C2X, C2Y, DONE);
    modport slave  (input DUT_RST, X, Y, output C1X, C1Y, C2X, C2Y, DONE);

endinterface

// File: rtl/laser_cover_unit.sv
// Combinational test: is a point within radius^2 COVER_R2 of either centre.
module laser_cover_unit
    import laser_pkg::*;
(
    input  point_t pt,
    input  point_t c1,
    input  point_t c2,
    output logic   covered
);

    always_comb begin
        covered = (dist2(pt.x, pt.y, c1.x, c1.y) <= 9'(COVER_R2)) ||
                  (dist2(pt.x, pt.y, c2.x, c2.y) <= 9'(COVER_R2));
    end

endmodule

// File: rtl/laser_host.sv
// LASER host: buffers a pattern, resets and feeds the engine, waits for DONE
// under a cycle budget, then scores coverage of the captured centres.
module laser_host
    import laser_pkg::*;
#(
    parameter int unsigned MAX_CYC   = 50000,
    parameter int unsigned STUCK_MAX = 10
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          LD_VALID,
    input  logic [3:0]    LD_X,
    input  logic [3:0]    LD_Y,
    output logic          LOAD_FULL,
    input  logic          START,
    output logic          BUSY,
    output logic          RESULT_VALID,
    output logic [5:0]    COVER,
    output logic [16:0]   CYCLES,
    output logic          TIMEOUT,
    output logic          ERR_EARLY,
    output logic          ERR_STUCK,
    laser_host_if.master  lsr
);

    localparam logic [5:0]  NPTS_W    = 6'(NPTS);
    localparam logic [5:0]  LAST      = 6'(NPTS - 1);
    localparam logic [1:0]  DRST_LAST = 2'(DRST_CYC - 1);
    localparam logic [7:0]  STUCK_LIM = 8'(STUCK_MAX);
    localparam logic [16:0] CYC_LIM   = 17'(MAX_CYC);

    point_t pts_q [NPTS];

    state_t        state_q, state_d;
    logic [5:0]    ptr_q, ptr_d;
    logic [5:0]    idx_q, idx_d;
    logic [7:0]    stall_q, stall_d;
    logic [1:0]    drst_q, drst_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    cover_q, cover_d;
    logic [16:0]   cycles_q, cycles_d;
    logic          tmo_q, tmo_d;
    logic          early_q, early_d;
    logic          stuck_q, stuck_d;
    point_t        c1_q, c1_d;
    point_t        c2_q, c2_d;
    point_t        pt_q, pt_d;
    logic          dut_rst_q, dut_rst_d;
    logic          rv_q, rv_d;
    logic          ld_we;
    logic          covered;
    logic          load_full;
    logic [5:0]    idx_nxt;
    logic [7:0]    stall_inc;
    logic [16:0]   cyc_inc;

    assign load_full = (ptr_q == NPTS_W);
    assign idx_nxt   = idx_q + 6'd1;
    assign stall_inc = stall_q + 8'd1;
    assign cyc_inc   = (&cycles_q) ? cycles_q : cycles_q + 17'd1;

    // Single cover unit, time-multiplexed over the buffer during SCORE.
    laser_cover_unit u_cover (
        .pt      (pts_q[idx_q]),
        .c1      (c1_q),
        .c2      (c2_q),
        .covered (covered)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        stall_d   = stall_q;
        drst_d    = drst_q;
        cnt_d     = cnt_q;
        cover_d   = cover_q;
        cycles_d  = cycles_q;
        tmo_d     = tmo_q;
        early_d   = early_q;
        stuck_d   = stuck_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        pt_d      = '0;
        dut_rst_d = 1'b0;
        rv_d      = 1'b0;
        ld_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // START takes priority over a same-cycle load.
                if (START && load_full) begin
                    state_d   = ST_DRST;
                    dut_rst_d = 1'b1;
                    drst_d    = '0;
                    cover_d   = '0;
                    cycles_d  = '0;
                    tmo_d     = 1'b0;
                    early_d   = 1'b0;
                    stuck_d   = 1'b0;
                end else if (LD_VALID && !load_full) begin
                    ld_we = 1'b1;
                    ptr_d = ptr_q + 6'd1;
                end
            end
            ST_DRST: begin
                if (drst_q == DRST_LAST) begin
                    state_d = ST_FEED;
                    idx_d   = '0;
                    stall_d = '0;
                    pt_d    = pts_q[0];
                end else begin
                    drst_d    = drst_q + 2'd1;
                    dut_rst_d = 1'b1;
                end
            end
            ST_FEED: begin
                if (!lsr.DONE) begin
                    if (idx_q == LAST) begin
                        state_d  = ST_RUN;
                        cycles_d = '0;
                    end else begin
                        idx_d = idx_nxt;
                        pt_d  = pts_q[idx_nxt];
                    end
                end else if (idx_q == '0) begin
                    stall_d = stall_inc;
                    if (stall_inc > STUCK_LIM) begin
                        stuck_d = 1'b1;
                        cover_d = '0;
                        state_d = ST_REPORT;
                        rv_d    = 1'b1;
                    end else begin
                        pt_d = pts_q[0];
                    end
                end else begin
                    early_d = 1'b1;
                    cover_d = '0;
                    state_d = ST_REPORT;
                    rv_d    = 1'b1;
                end
            end
            ST_RUN: begin
                cycles_d = cyc_inc;
                if (lsr.DONE || (cyc_inc > CYC_LIM)) begin
                    c1_d    = '{x: lsr.C1X, y: lsr.C1Y};
                    c2_d    = '{x: lsr.C2X, y: lsr.C2Y};
                    tmo_d   = tmo_q | !lsr.DONE;
                    state_d = ST_SCORE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SCORE: begin
                cnt_d = cnt_q + {5'b0, covered};
                if (idx_q == LAST) begin
                    cover_d = cnt_d;
                    state_d = ST_REPORT;
                    rv_d    = 1'b1;
                end else begin
                    idx_d = idx_nxt;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            stall_q   <= '0;
            drst_q    <= '0;
            cnt_q     <= '0;
            cover_q   <= '0;
            cycles_q  <= '0;
            tmo_q     <= 1'b0;
            early_q   <= 1'b0;
            stuck_q   <= 1'b0;
            c1_q      <= '0;
            c2_q      <= '0;
            pt_q      <= '0;
            dut_rst_q <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            stall_q   <= stall_d;
            drst_q    <= drst_d;
            cnt_q     <= cnt_d;
            cover_q   <= cover_d;
            cycles_q  <= cycles_d;
            tmo_q     <= tmo_d;
            early_q   <= early_d;
            stuck_q   <= stuck_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            pt_q      <= pt_d;
            dut_rst_q <= dut_rst_d;
            rv_q      <= rv_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (ld_we) begin
            pts_q[ptr_q] <= '{x: LD_X, y: LD_Y};
        end
    end

    assign LOAD_FULL    = load_full;
    assign BUSY         = (state_q != ST_IDLE);
    assign RESULT_VALID = rv_q;
    assign COVER        = cover_q;
    assign CYCLES       = cycles_q;
    assign TIMEOUT      = tmo_q;
    assign ERR_EARLY    = early_q;
    assign ERR_STUCK    = stuck_q;
    assign lsr.DUT_RST  = dut_rst_q;
    assign lsr.X        = pt_q.x;
    assign lsr.Y        = pt_q.y;

endmodule

// File: tb/tb_laser_host.sv
// Scoreboarded bench for laser_host with a behavioural LASER engine model.
module tb_laser_host;
    import laser_pkg::*;

    localparam int unsigned MAXC = 200;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LD_VALID = 1'b0;
    logic        START = 1'b0;
    logic [3:0]  LD_X = '0;
    logic [3:0]  LD_Y = '0;
    logic        LOAD_FULL, BUSY, RESULT_VALID, TIMEOUT, ERR_EARLY, ERR_STUCK;
    logic [5:0]  COVER;
    logic [16:0] CYCLES;

    laser_host_if lif ();

    laser_host #(.MAX_CYC(MAXC), .STUCK_MAX(10)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .LD_VALID     (LD_VALID),
        .LD_X         (LD_X),
        .LD_Y         (LD_Y),
        .LOAD_FULL    (LOAD_FULL),
        .START        (START),
        .BUSY         (BUSY),
        .RESULT_VALID (RESULT_VALID),
        .COVER        (COVER),
        .CYCLES       (CYCLES),
        .TIMEOUT      (TIMEOUT),
        .ERR_EARLY    (ERR_EARLY),
        .ERR_STUCK    (ERR_STUCK),
        .lsr          (lif)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0]  cov;
        logic [16:0] cycles;
        logic        tmo;
        logic        early;
        logic        stuck;
    } res_t;

    res_t   exp_q [$];
    int     n_vec = 0;
    int     n_err = 0;
    int     n_rv  = 0;
    point_t pat [NPTS];

    // Engine model configuration, changed only while the model is idle.
    int stall_n   = 0;
    int run_len   = 100;
    int early_idx = -1;
    bit no_done   = 1'b0;
    bit feed_chk  = 1'b0;

    int t       = 0;
    int k       = 0;
    int rst_cnt = 0;
    bit act_m   = 1'b0;
    bit rv_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t mk_res(input int c, input int cy, input bit tm, input bit ea, input bit st);
        res_t r;
        r.cov    = 6'(c);
        r.cycles = 17'(cy);
        r.tmo    = tm;
        r.early  = ea;
        r.stuck  = st;
        return r;
    endfunction

    // LASER model: t=0 is the first cycle after DUT_RST falls; DONE set here is sampled at the next edge.
    always @(negedge CLK) begin
        if (RST) begin
            act_m    = 1'b0;
            rst_cnt  = 0;
            lif.DONE = 1'b0;
        end else if (lif.DUT_RST) begin
            act_m    = 1'b1;
            t        = -1;
            rst_cnt++;
            lif.DONE = 1'b0;
        end else if (act_m) begin
            if (RESULT_VALID) begin
                act_m = 1'b0;
            end else begin
                t++;
                if (t == 0) begin
                    if (feed_chk) chk("drst_len", 64'(rst_cnt), 64'd2);
                    rst_cnt = 0;
                end
                if (feed_chk && t <= 39 + stall_n) begin
                    k = (t < stall_n) ? 0 : t - stall_n;
                    chk($sformatf("feed_xy[%0d]", t), {lif.X, lif.Y}, 64'(pat[k]));
                end
                lif.DONE = (t < stall_n) || (early_idx >= 0 && t == early_idx) ||
                           (!no_done && t >= 39 + stall_n + run_len);
            end
        end
    end

    // Result monitor: pops one expectation per RESULT_VALID pulse.
    always @(negedge CLK) begin
        res_t e;
        if (rv_prev) chk("rv_pulse", 64'(RESULT_VALID), 64'd0);
        rv_prev = RESULT_VALID && !RST;
        if (!RST && RESULT_VALID) begin
            n_rv++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL result_unexpected: RESULT_VALID with no pending run, cover %0d", COVER);
            end else begin
                e = exp_q.pop_front();
                chk("cover", 64'(COVER), 64'(e.cov));
                chk("cycles", 64'(CYCLES), 64'(e.cycles));
                chk("flags_tmo_early_stuck", {TIMEOUT, ERR_EARLY, ERR_STUCK}, {e.tmo, e.early, e.stuck});
            end
        end
    end

    task automatic set_pat_a();
        for (int i = 0; i < int'(NPTS); i++) pat[i] = '{x: 4'd8, y: 4'd8};
    endtask

    // Boundary pattern against centres (0,0)/(15,15): exactly 6 covered.
    task automatic set_pat_b();
        pat[0] = '{x: 4'd4,  y: 4'd0};
        pat[1] = '{x: 4'd0,  y: 4'd4};
        pat[2] = '{x: 4'd3,  y: 4'd3};
        pat[3] = '{x: 4'd15, y: 4'd11};
        pat[4] = '{x: 4'd11, y: 4'd15};
        pat[5] = '{x: 4'd12, y: 4'd12};
        pat[6] = '{x: 4'd0,  y: 4'd0};
        pat[7] = '{x: 4'd15, y: 4'd15};
        for (int i = 8; i < int'(NPTS); i++) pat[i] = '{x: 4'(4 + i % 8), y: 4'(11 - i % 8)};
    endtask

    task automatic set_centres(input logic [3:0] ax, input logic [3:0] ay,
                               input logic [3:0] bx, input logic [3:0] by);
        lif.C1X = ax;
        lif.C1Y = ay;
        lif.C2X = bx;
        lif.C2Y = by;
    endtask

    task automatic set_cfg(input int s, input int r, input int ei, input bit nd, input bit fc);
        stall_n   = s;
        run_len   = r;
        early_idx = ei;
        no_done   = nd;
        feed_chk  = fc;
    endtask

    // Loads pat[first..first+n-1]; indices past the buffer load (0,0).
    task automatic load_pts(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            @(negedge CLK);
            LD_VALID = 1'b1;
            LD_X     = (i < int'(NPTS)) ? pat[i].x : 4'd0;
            LD_Y     = (i < int'(NPTS)) ? pat[i].y : 4'd0;
        end
        @(negedge CLK);
        LD_VALID = 1'b0;
    endtask

    task automatic start_run();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run_expect(input res_t e);
        int base;
        exp_q.push_back(e);
        start_run();
        chk("busy_after_start", 64'(BUSY), 64'd1);
        base = n_rv;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            if (n_rv != base) break;
        end
        if (n_rv == base) begin
            n_vec++;
            n_err++;
            $display("FAIL result_wait: no RESULT_VALID within 3000 cycles, busy %0d", BUSY);
            exp_q.delete();
        end
        @(negedge CLK);
        @(negedge CLK);
        chk("ptr_cleared", 64'(LOAD_FULL), 64'd0);
        chk("cover_hold", 64'(COVER), 64'(e.cov));
    endtask

    initial begin
        set_pat_a();
        set_centres(4'd8, 4'd8, 4'd8, 4'd8);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_outputs", {LOAD_FULL, BUSY, RESULT_VALID, COVER, CYCLES, TIMEOUT, ERR_EARLY,
                              ERR_STUCK, lif.DUT_RST, lif.X, lif.Y}, 64'd0);

        start_run();
        chk("start_ignored_empty", 64'(BUSY), 64'd0);

        load_pts(0, 39);
        chk("not_full_39", 64'(LOAD_FULL), 64'd0);
        load_pts(39, 1);
        chk("full_40", 64'(LOAD_FULL), 64'd1);

        // All points on both centres, DONE after 100 RUN cycles.
        set_cfg(0, 100, -1, 1'b0, 1'b1);
        run_expect(mk_res(40, 100, 1'b0, 1'b0, 1'b0));

        // Radius boundary points.
        set_pat_b();
        set_centres(4'd0, 4'd0, 4'd15, 4'd15);
        load_pts(0, int'(NPTS));
        set_cfg(0, 7, -1, 1'b0, 1'b1);
        run_expect(mk_res(6, 7, 1'b0, 1'b0, 1'b0));

        // DONE high for 5 cycles at feed start: 45-cycle feed, no error.
        load_pts(0, int'(NPTS));
        set_cfg(5, 30, -1, 1'b0, 1'b1);
        run_expect(mk_res(6, 30, 1'b0, 1'b0, 1'b0));

        // DONE never rises: budget expires, held centres are scored.
        load_pts(0, int'(NPTS));
        set_cfg(0, 0, -1, 1'b1, 1'b1);
        run_expect(mk_res(6, int'(MAXC) + 1, 1'b1, 1'b0, 1'b0));

        // DONE while point 17 is on the bus.
        load_pts(0, int'(NPTS));
        set_cfg(0, 0, 17, 1'b1, 1'b0);
        run_expect(mk_res(0, 0, 1'b0, 1'b1, 1'b0));

        // DONE stuck high from feed start.
        load_pts(0, int'(NPTS));
        set_cfg(1000, 0, -1, 1'b1, 1'b0);
        run_expect(mk_res(0, 0, 1'b0, 1'b0, 1'b1));

        // Reset during SCORE, then reload (41 writes) and rerun.
        set_pat_a();
        set_centres(4'd8, 4'd8, 4'd8, 4'd8);
        load_pts(0, int'(NPTS));
        set_cfg(0, 100, -1, 1'b0, 1'b0);
        start_run();
        for (int c = 0; c < 500; c++) begin
            @(posedge CLK);
            if (lif.DONE) break;
        end
        if (!lif.DONE) begin
            n_vec++;
            n_err++;
            $display("FAIL done_wait: model DONE never rose, busy %0d", BUSY);
        end
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_score", {BUSY, lif.DUT_RST, LOAD_FULL, RESULT_VALID, COVER, CYCLES,
                              TIMEOUT, ERR_EARLY, ERR_STUCK}, 64'd0);
        RST = 1'b0;
        load_pts(0, int'(NPTS) + 1);
        chk("full_after_41", 64'(LOAD_FULL), 64'd1);
        set_cfg(0, 100, -1, 1'b0, 1'b1);
        run_expect(mk_res(40, 100, 1'b0, 1'b0, 1'b0));

        repeat (5) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/laser_host.md
# laser_host

Active-side host for the LASER point-coverage engine. It buffers a 40-point pattern and applies the LASER reset sequence. It then streams the points on X/Y, one per cycle, and waits for DONE with a cycle budget. Finally it captures C1/C2 and scores coverage in hardware: a point is covered when its squared distance to either centre is at most 16. It sits between a pattern loader (CPU/ROM) and a LASER instance and replaces a simulation-only driver for FPGA/emulation regression.

## Interface
- `NPTS`, 40: points per pattern.
- `MAX_CYC`, 50000: RUN-phase cycle budget before forced capture.
- `STUCK_MAX`, 10: cycles DONE may stay high at feed start before error.
- `CLK` in 1: single clock; all logic on rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `LD_VALID` in 1: write `LD_X`/`LD_Y` into the point buffer.
- `LD_X`, `LD_Y` in 4: point coordinates.
- `LOAD_FULL` out 1: buffer holds `NPTS` points.
- `START` in 1: begin a run; 1-cycle pulse.
- `DUT_RST` out 1: drives LASER `RST`.
- `X`, `Y` out 4: drive LASER `X`/`Y`; registered.
- `C1X`, `C1Y`, `C2X`, `C2Y` in 4: LASER results.
- `DONE` in 1: LASER completion.
- `BUSY` out 1: not IDLE.
- `RESULT_VALID` out 1: 1-cycle pulse when `COVER` is final.
- `COVER` out 6: covered-point count, 0..40.
- `CYCLES` out 17: RUN cycles used, saturating.
- `TIMEOUT`, `ERR_EARLY`, `ERR_STUCK` out 1: sticky status flags, cleared by the next accepted `START`.

## Operation
- Reset values: all outputs 0; `DUT_RST`=0; FSM=IDLE; load pointer=0.
- Load:
  - Accepted only in IDLE.
  - Each `LD_VALID` writes to entry `ptr` and then increments `ptr`.
  - At `ptr==NPTS`, further writes are ignored (saturate, no wrap).
  - `LOAD_FULL = (ptr==NPTS)`.
- `START` is accepted only when IDLE and `LOAD_FULL`; otherwise it is ignored.
- States:
  - IDLE → DRST on `START`. On acceptance, clear `COVER`, `CYCLES` and all flags.
  - DRST (2 cycles): `DUT_RST`=1, `X`/`Y`=0. Then FEED with `idx`=0, `DUT_RST`=0.
  - FEED:
    - Present `point[idx]`.
    - If `DONE`==0: `idx++`; after `idx`==`NPTS`-1 is presented, go to RUN with `CYCLES`=0.
    - If `DONE`==1 and `idx`==0: hold and increment the stall count. Stall count > `STUCK_MAX` → set `ERR_STUCK`, go to REPORT with `COVER`=0.
    - If `DONE`==1 and `idx`>0: set `ERR_EARLY`, go to REPORT with `COVER`=0.
  - RUN:
    - Increment `CYCLES` every cycle.
    - `DONE`==1 → capture C1/C2, go to SCORE.
    - `CYCLES` > `MAX_CYC` → capture C1/C2, set `TIMEOUT`, go to SCORE.
  - SCORE (`NPTS` cycles): one point per cycle; increment the count if covered.
  - REPORT (1 cycle): `RESULT_VALID`=1, then IDLE with `ptr` cleared.
- Arithmetic:
  - `dx`/`dy` are 5-bit signed differences of unsigned 4-bit values.
  - Squares are 8 bits; the sum is 9 bits (max 450).
  - Covered = (d1 ≤ 16) OR (d2 ≤ 16); a point on a centre is covered.
- Captured centre values containing X/Z are not detected in RTL; the bench checks for them.

## Timing
- `DUT_RST` asserted in the 2 cycles after the `START` edge.
- The first point appears on `X`/`Y` in the cycle after `DUT_RST` falls. Point k is stable for one cycle, ≥1 ns hold after the edge.
- With no stalls, FEED takes exactly 40 cycles.
- Score latency is `NPTS`+1 cycles from capture to `RESULT_VALID`.
- `COVER`, `CYCLES` and flags hold until the next accepted `START`.
- `RST` mid-run returns to IDLE within 1 cycle, clears the buffer pointer and drops `DUT_RST`.
- `START` and `LD_VALID` in the same IDLE cycle: `START` wins and the load is ignored.

## Structure
- `laser_pkg`:
  - `point_t` (4-bit x, y) and the FSM state enum.
  - `NPTS`, `COVER_R2`=16, `DRST_CYC`=2.
  - Function `dist2(x0,y0,x1,y1)`, returning a 9-bit result.
- One sub-module `laser_cover_unit`: combinational point-vs-two-centres test, output `covered`. The host instantiates it once and time-multiplexes it over SCORE.

## Test plan
- Load 40 points all at (8,8); LASER model returns C1=C2=(8,8) after 100 cycles → `COVER`=40, `CYCLES`=100, no flags.
- Points on the radius boundary, (4,0) and (0,4) from centre (0,0), plus point (3,3), which has d=18 → first two covered, (3,3) not.
- Model holds `DONE`=1 for 5 cycles at FEED start, then behaves normally → no error, and FEED spans 45 cycles.
- Model never asserts `DONE` → `TIMEOUT`=1, capture at `CYCLES`=`MAX_CYC`+1, score of the held C values.
- Model asserts `DONE` at `idx`=17 → `ERR_EARLY`=1, `COVER`=0, `RESULT_VALID` pulse.
- `RST` during SCORE, then reload and rerun → clean second result identical to a fresh run; 41st `LD_VALID` ignored.
